clock_divider_bank: RTL and testbench

Parametrised bank of NUM_CH independent clock dividers driven from the single board clock. It replaces fixed-threshold dividers with runtime-programmable half-period thresholds, per-channel enable and glitch-free threshold changes. It adds one-cycle rise and fall strobes for logic that must stay on clk, and a bank-wide phase restart.
Default configuration reproduces the existing FSM clock (threshold 125) and ILA sample clock (threshold 250000).

---
 rtl/clkdiv_pkg.sv | 22 ++
 rtl/clock_divider_bank_if.sv | 24 ++
 rtl/clock_divider_channel.sv | 124 ++++++++++++
 rtl/clock_divider_bank.sv | 59 +++++
 tb/tb_clock_divider_bank.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants, state type and threshold helper for the divider bank
package clkdiv_pkg;

    localparam int CNT_W_DEF = 24;
    localparam int THR_FSM   = 125;
    localparam int THR_ILA   = 250000;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_RUN      = 2'd1,
        CH_STOPPING = 2'd2
    } ch_state_e;

    // Half-period threshold for a target output frequency: f_clk / (2 * f_out) - 1.
    function automatic int unsigned thr_from_freq(input longint unsigned f_clk,
                                                  input longint unsigned f_out);
        longint unsigned half;
        half = f_clk / (64'd2 * f_out);
        return 32'(half - 64'd1);
    endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - threshold write / readback bus of the divider bank
interface clock_divider_bank_if #(
    parameter int CNT_W = 24,
    parameter int CH_W  = 1
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_thr;
    logic [CNT_W-1:0] cfg_rd_thr;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_thr,
        input  cfg_rd_thr
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_thr,
        output cfg_rd_thr
    );
endinterface

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider: counter, shadowed threshold and enable FSM
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_THR = CNT_W'(THR_FSM),
    parameter bit               RST_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch_en,
    input  logic             sync_restart,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_thr,
    output logic [CNT_W-1:0] thr_active,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             active
);

    ch_state_e        state_q;
    ch_state_e        state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr_shadow;
    logic             pending;
    logic             terminal;
    logic             restart;
    logic             stop_now;

    assign terminal = (cnt == thr_active);
    assign restart  = sync_restart && ((state_q != CH_IDLE) || ch_en);
    // Dropping the enable during the low phase stops at once; no pulse is cut short.
    assign stop_now = (state_q == CH_RUN) && !ch_en && !clk_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_EN ? CH_RUN : CH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ch_en ? CH_RUN : CH_IDLE;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (ch_en) state_d = CH_RUN;
                end
                CH_RUN: begin
                    if (!ch_en) begin
                        if (!clk_out || terminal) state_d = CH_IDLE;
                        else                      state_d = CH_STOPPING;
                    end
                end
                CH_STOPPING: begin
                    if (ch_en)         state_d = CH_RUN;
                    else if (terminal) state_d = CH_IDLE;
                end
                default: state_d = CH_IDLE;
            endcase
        end
    end

    always_comb begin
        active = (state_q != CH_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            clk_out    <= 1'b0;
            rise_tick  <= 1'b0;
            fall_tick  <= 1'b0;
            thr_active <= RST_THR;
            thr_shadow <= RST_THR;
            pending    <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            if (restart) begin
                cnt        <= '0;
                clk_out    <= 1'b0;
                fall_tick  <= clk_out;
                thr_active <= cfg_we ? cfg_thr : thr_shadow;
                if (cfg_we) thr_shadow <= cfg_thr;
                pending    <= 1'b0;
            end else if ((state_q == CH_IDLE) || stop_now) begin
                cnt        <= '0;
                clk_out    <= 1'b0;
                thr_active <= cfg_we ? cfg_thr : thr_shadow;
                if (cfg_we) thr_shadow <= cfg_thr;
                pending    <= 1'b0;
            end else begin
                if (terminal) begin
                    cnt       <= '0;
                    clk_out   <= ~clk_out;
                    rise_tick <= ~clk_out;
                    fall_tick <= clk_out;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                // New thresholds only take effect at a falling transition, so every
                // low phase and full period uses a single threshold.
                if (terminal && clk_out) begin
                    if (cfg_we) begin
                        thr_active <= cfg_thr;
                        thr_shadow <= cfg_thr;
                    end else if (pending) begin
                        thr_active <= thr_shadow;
                    end
                    pending <= 1'b0;
                end else if (cfg_we) begin
                    thr_shadow <= cfg_thr;
                    pending    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of programmable clock dividers with write decode and readback
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH  = 2,
    parameter int                      CNT_W   = CNT_W_DEF,
    parameter int                      CH_W    = 1,
    parameter logic [NUM_CH*CNT_W-1:0] RST_THR = {CNT_W'(THR_ILA), CNT_W'(THR_FSM)},
    parameter logic [NUM_CH-1:0]       RST_EN  = {NUM_CH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_restart,
    clock_divider_bank_if.slave cfg,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   rise_tick,
    output logic [NUM_CH-1:0]   fall_tick,
    output logic [NUM_CH-1:0]   active
);

    logic [CNT_W-1:0] thr_act [NUM_CH];
    logic [CNT_W-1:0] rd_thr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;

        // Addresses at or above NUM_CH match no channel, so such writes vanish.
        assign ch_we = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        clock_divider_channel #(
            .CNT_W   (CNT_W),
            .RST_THR (RST_THR[i*CNT_W +: CNT_W]),
            .RST_EN  (RST_EN[i])
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .ch_en        (ch_en[i]),
            .sync_restart (sync_restart),
            .cfg_we       (ch_we),
            .cfg_thr      (cfg.cfg_thr),
            .thr_active   (thr_act[i]),
            .clk_out      (clk_out[i]),
            .rise_tick    (rise_tick[i]),
            .fall_tick    (fall_tick[i]),
            .active       (active[i])
        );
    end

    always_comb begin
        rd_thr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) rd_thr = thr_act[i];
        end
    end

    assign cfg.cfg_rd_thr = rd_thr;

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed self-checking bench with a tick scoreboard
module tb_clock_divider_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 24;
    localparam int CH_W   = 2;

    typedef struct packed {
        bit rise;
        int cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] rise_tick;
    logic [NUM_CH-1:0] fall_tick;
    logic [NUM_CH-1:0] active;

    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    ev_t q0[$];
    ev_t q1[$];

    clock_divider_bank_if #(.CNT_W(CNT_W), .CH_W(CH_W)) cfg_bus ();

    clock_divider_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg          (cfg_bus),
        .clk_out      (clk_out),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .active       (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int c, input bit rise, input int t);
        ev_t e;
        e.rise = rise;
        e.cyc  = t;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic push_run(input int c, input int thr, input int start, input int stop);
        for (int k = 1; start + k * (thr + 1) < stop; k++) begin
            push_ev(c, (k % 2) == 1, start + k * (thr + 1));
        end
    endtask

    task automatic pop_ev(input int c);
        ev_t e;
        if (c == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic mon_one(input int c);
        ev_t e;
        bit  have;
        bit  done;
        bit  r;
        bit  f;
        r    = rise_tick[c];
        f    = fall_tick[c];
        done = 1'b0;
        e    = '0;
        have = 1'b0;
        while (!done) begin
            have = (c == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (have) begin
                if (c == 0) e = q0[0];
                else        e = q1[0];
            end
            if (have && e.cyc < cyc) begin
                check($sformatf("missed_tick_ch%0d", c), longint'(cyc), longint'(e.cyc));
                pop_ev(c);
            end else begin
                done = 1'b1;
            end
        end
        if (r || f) begin
            if (have && e.cyc == cyc) begin
                check($sformatf("tick_kind_ch%0d", c), longint'(r), longint'(e.rise));
                check($sformatf("tick_level_ch%0d", c), longint'(clk_out[c]), longint'(r));
                pop_ev(c);
            end else begin
                check($sformatf("unexpected_tick_ch%0d", c), longint'(cyc),
                      have ? longint'(e.cyc) : -1);
            end
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int thr);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = CH_W'(ch);
        cfg_bus.cfg_thr = CNT_W'(thr);
        #1;
    endtask

    task automatic wr_end();
        cfg_bus.cfg_we = 1'b0;
        cfg_bus.cfg_ch = '0;
        #1;
    endtask

    task automatic rd_check(input string tag, input int ch, input int exp);
        cfg_bus.cfg_ch = CH_W'(ch);
        #1;
        check(tag, longint'(cfg_bus.cfg_rd_thr), longint'(exp));
    endtask

    initial begin
        int r;
        int s;
        int s2;
        int s3;
        rst_n           = 1'b0;
        ch_en           = 2'b11;
        sync_restart    = 1'b0;
        cfg_bus.cfg_we  = 1'b0;
        cfg_bus.cfg_ch  = '0;
        cfg_bus.cfg_thr = '0;

        fork
            begin
                forever begin
                    @(negedge clk);
                    mon_one(0);
                    mon_one(1);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_clk_out", longint'(clk_out), 0);
        check("rst_ticks", longint'({rise_tick, fall_tick}), 0);
        check("rst_active", longint'(active), 3);
        rd_check("rst_thr_ch0", 0, 125);
        rd_check("rst_thr_ch1", 1, 250000);
        cfg_bus.cfg_ch = '0;

        @(negedge clk);
        rst_n = 1'b1;
        r     = cyc;
        push_ev(0, 1'b1, r + 126);
        push_ev(0, 1'b0, r + 252);

        // Write 3 during the high phase: takes effect at the next fall.
        wait_cyc(r + 146);
        wr(0, 3);
        check("rd_during_high_write", longint'(cfg_bus.cfg_rd_thr), 125);
        wait_cyc(r + 147);
        wr_end();
        push_ev(0, 1'b1, r + 256);
        push_ev(0, 1'b0, r + 260);
        push_ev(0, 1'b1, r + 264);
        push_ev(0, 1'b0, r + 268);
        wait_cyc(r + 251);
        check("rd_pending_125", longint'(cfg_bus.cfg_rd_thr), 125);
        wait_cyc(r + 252);
        check("rd_loaded_3", longint'(cfg_bus.cfg_rd_thr), 3);

        // Write 9 in the exact cycle of the falling transition.
        wait_cyc(r + 267);
        wr(0, 9);
        check("rd_before_fall_write", longint'(cfg_bus.cfg_rd_thr), 3);
        wait_cyc(r + 268);
        wr_end();
        check("rd_fall_write_9", longint'(cfg_bus.cfg_rd_thr), 9);
        push_ev(0, 1'b1, r + 278);
        push_ev(0, 1'b0, r + 288);
        push_ev(0, 1'b1, r + 298);
        push_ev(0, 1'b0, r + 308);

        // Out-of-range channel write is ignored.
        wait_cyc(r + 270);
        wr(2, 77);
        check("rd_bad_ch", longint'(cfg_bus.cfg_rd_thr), 0);
        wait_cyc(r + 271);
        wr_end();
        check("rd_ch0_after_bad", longint'(cfg_bus.cfg_rd_thr), 9);
        rd_check("rd_ch1_after_bad", 1, 250000);
        cfg_bus.cfg_ch = '0;

        // Low-phase write of 125 waits for the next fall.
        wait_cyc(r + 290);
        wr(0, 125);
        wait_cyc(r + 291);
        wr_end();
        check("rd_low_write_pending", longint'(cfg_bus.cfg_rd_thr), 9);
        wait_cyc(r + 308);
        check("rd_low_write_loaded", longint'(cfg_bus.cfg_rd_thr), 125);
        push_ev(0, 1'b1, r + 434);
        push_ev(0, 1'b0, r + 560);

        // Disable 10 cycles into the high phase: high phase completes, then stop.
        wait_cyc(r + 443);
        ch_en[0] = 1'b0;
        wait_cyc(r + 559);
        check("stop_still_high", longint'(clk_out[0]), 1);
        check("stop_still_active", longint'(active[0]), 1);
        wait_cyc(r + 560);
        check("stop_fell", longint'(clk_out[0]), 0);
        check("stop_inactive", longint'(active[0]), 0);
        wait_cyc(r + 800);
        check("stopped_low", longint'(clk_out[0]), 0);
        check("stopped_inactive", longint'(active[0]), 0);
        ch_en[0] = 1'b1;
        push_ev(0, 1'b1, r + 927);
        wait_cyc(r + 801);
        check("restart_active", longint'(active[0]), 1);

        // Program 4 / 9, then phase-align with sync_restart at several offsets.
        wait_cyc(r + 940);
        wr(0, 4);
        wait_cyc(r + 941);
        wr(1, 9);
        wait_cyc(r + 942);
        wr_end();
        wait_cyc(r + 950);
        s            = r + 951;
        s2           = s + 37;
        s3           = s2 + 5;
        sync_restart = 1'b1;
        push_ev(0, 1'b0, s);
        push_run(0, 4, s, s2);
        push_run(1, 9, s, s2);
        push_ev(0, 1'b0, s2);
        push_ev(1, 1'b0, s2);
        wait_cyc(s);
        sync_restart = 1'b0;
        check("sync1_outputs_low", longint'(clk_out), 0);
        rd_check("sync1_thr_ch0", 0, 4);
        rd_check("sync1_thr_ch1", 1, 9);
        cfg_bus.cfg_ch = '0;

        wait_cyc(s2 - 1);
        sync_restart = 1'b1;
        wait_cyc(s2);
        sync_restart = 1'b0;
        check("sync2_outputs_low", longint'(clk_out), 0);

        // Restart lands on ch0's terminal count: restart wins, no rise.
        wait_cyc(s3 - 1);
        sync_restart = 1'b1;
        push_run(0, 4, s3, s3 + 36);
        push_run(1, 9, s3, s3 + 36);
        wait_cyc(s3);
        sync_restart = 1'b0;
        check("sync3_priority_low", longint'(clk_out), 0);

        wait_cyc(s3 + 36);
        check("pre_reset_high", longint'(clk_out), 3);

        // Asynchronous reset between clock edges.
        wait_cyc(s3 + 37);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", longint'(clk_out), 0);
        check("async_rst_ticks", longint'({rise_tick, fall_tick}), 0);
        check("async_rst_active", longint'(active), 3);
        check("async_rst_thr_ch0", longint'(cfg_bus.cfg_rd_thr), 125);
        cfg_bus.cfg_ch = 2'd1;
        #0.5;
        check("async_rst_thr_ch1", longint'(cfg_bus.cfg_rd_thr), 250000);
        cfg_bus.cfg_ch = '0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty_ch0", longint'(q0.size()), 0);
        check("scoreboard_empty_ch1", longint'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
